boot_hex_formatter: RTL and testbench

Converts a stream of data words into ASCII hexadecimal characters for a byte-wide character transmitter (UART TX). It is the transmit-side counterpart of the boot hex loader: it is used for memory readback and for dumping a boot image. Its character stream, fed into the hex parser, reproduces the same words at the same addresses. Words are emitted MSB nibble first, upper-case, with CR LF after every `words_per_line` words or on an explicit flush.

---
 rtl/boot_hex_formatter_if.sv | 32 +++
 rtl/boot_hex_formatter.sv | 132 +++++++++++++
 tb/tb_boot_hex_formatter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_hex_formatter_if.sv
// Purpose: word-in / character-out bus of the boot hex formatter.
// Latency: none, this is wiring only.
// Backpressure: in_valid/in_ready on words, out_valid/out_ready on characters.
// Ports: in_valid/in_ready/in_data (word in), flush (end partial line),
//        out_valid/out_ready/out_char (ASCII out), sent_address, busy (status).
interface boot_hex_formatter_if #(
  parameter int address_width = 32,
  parameter int data_width    = 32,
  parameter int char_width    = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [data_width-1:0]    in_data;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [char_width-1:0]    out_char;
  logic [address_width-1:0] sent_address;
  logic                     busy;

  // master: the word source and character sink around the formatter
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_char, sent_address, busy
  );

  // slave: the formatter itself
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_char, sent_address, busy
  );
endinterface

// File: rtl/boot_hex_formatter.sv
// Purpose: formats words as upper-case ASCII hex (MSB nibble first) with CR LF line ends.
// Latency: first character one cycle after word acceptance; one character per cycle.
// Backpressure: out_ready stalls with out_char held; in_ready is high only in IDLE.
// Ports: clk, reset (sync, active-high), bus (boot_hex_formatter_if.slave):
//        word input, flush, character output, sent_address and busy status.
module boot_hex_formatter #(
  parameter int address_width  = 32,
  parameter int data_width     = 32,
  parameter int char_width     = 8,
  parameter int words_per_line = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  boot_hex_formatter_if.slave   bus
);

  localparam int NIBBLES = data_width / 4;
  localparam int NIB_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int LINE_W  = (words_per_line > 1) ? $clog2(words_per_line) : 1;

  localparam logic [NIB_W-1:0]         LAST_NIB  = NIB_W'(NIBBLES - 1);
  localparam logic [LINE_W-1:0]        LAST_WORD = LINE_W'(words_per_line - 1);
  localparam logic [address_width-1:0] ADDR_STEP = address_width'(data_width / 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NIBBLE,
    S_CR,
    S_LF
  } state_e;

  state_e                   state_q, state_d;
  logic [data_width-1:0]    shift_q, shift_d;
  logic [NIB_W-1:0]         nib_cnt_q, nib_cnt_d;
  logic [LINE_W-1:0]        line_count_q, line_count_d;
  logic [address_width-1:0] sent_address_q, sent_address_d;

  logic                  in_ready;
  logic                  out_valid;
  logic [char_width-1:0] out_char;
  logic [3:0]            top_nib;
  logic [7:0]            hex_char;
  logic                  flush_line;

  // Character encoding of the nibble currently at the top of the word.
  assign top_nib  = shift_q[data_width-1 -: 4];
  assign hex_char = (top_nib < 4'd10) ? (8'h30 + {4'h0, top_nib})
                                      : (8'h37 + {4'h0, top_nib});

  // A flush only means something when a line has been started.
  assign flush_line = bus.flush && (line_count_q != '0);

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    nib_cnt_d      = nib_cnt_q;
    line_count_d   = line_count_q;
    sent_address_d = sent_address_q;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_char       = '0;

    case (state_q)
      S_IDLE: begin
        // Never depends on in_valid; flush takes priority over a new word.
        in_ready = !reset && !flush_line;
        if (flush_line) begin
          state_d = S_CR;
        end else if (bus.in_valid && in_ready) begin
          shift_d   = bus.in_data;
          nib_cnt_d = '0;
          state_d   = S_NIBBLE;
        end
      end
      S_NIBBLE: begin
        out_valid = 1'b1;
        out_char  = char_width'(hex_char);
        if (bus.out_ready) begin
          shift_d   = shift_q << 4;
          nib_cnt_d = nib_cnt_q + NIB_W'(1);
          if (nib_cnt_q == LAST_NIB) begin
            sent_address_d = sent_address_q + ADDR_STEP;
            if (line_count_q == LAST_WORD) begin
              line_count_d = '0;
              state_d      = S_CR;
            end else begin
              line_count_d = line_count_q + LINE_W'(1);
              state_d      = S_IDLE;
            end
          end
        end
      end
      S_CR: begin
        out_valid = 1'b1;
        out_char  = char_width'(8'h0D);
        if (bus.out_ready) state_d = S_LF;
      end
      S_LF: begin
        out_valid = 1'b1;
        out_char  = char_width'(8'h0A);
        if (bus.out_ready) begin
          line_count_d = '0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      shift_q        <= '0;
      nib_cnt_q      <= '0;
      line_count_q   <= '0;
      sent_address_q <= '0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      nib_cnt_q      <= nib_cnt_d;
      line_count_q   <= line_count_d;
      sent_address_q <= sent_address_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_char     = out_char;
  assign bus.sent_address = sent_address_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_boot_hex_formatter.sv
module tb_boot_hex_formatter;

  logic clk = 1'b0;
  logic rst1, rst2;
  always #5 clk = ~clk;

  // u1: one word per line, 32-bit address. u2: four words per line, 4-bit address.
  boot_hex_formatter_if #(.address_width(32), .data_width(32), .char_width(8)) b1 ();
  boot_hex_formatter_if #(.address_width(4),  .data_width(32), .char_width(8)) b2 ();

  boot_hex_formatter #(.address_width(32), .data_width(32), .char_width(8), .words_per_line(1))
    u1 (.clk(clk), .reset(rst1), .bus(b1));
  boot_hex_formatter #(.address_width(4), .data_width(32), .char_width(8), .words_per_line(4))
    u2 (.clk(clk), .reset(rst2), .bus(b2));

  int tests = 0;
  int fails = 0;

  logic [7:0]  q1[$];
  logic [7:0]  q2[$];
  int          lc1 = 0;
  int          lc2 = 0;
  logic        rand_rdy = 1'b0;

  // Reference parser fed by u1's character stream.
  logic [31:0] pw[$];
  logic [31:0] pa[$];
  logic [31:0] pacc = '0;
  int          pn = 0;
  logic [31:0] paddr = '0;

  logic [7:0]  exp1, exp2, held1, held2;
  logic        stall1 = 1'b0, stall2 = 1'b0, rs1 = 1'b0, rs2 = 1'b0;

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic push_word(input int which, input logic [31:0] w);
    for (int i = 7; i >= 0; i--) begin
      if (which == 1) q1.push_back(hexc(w[4*i +: 4]));
      else            q2.push_back(hexc(w[4*i +: 4]));
    end
    if (which == 1) begin
      q1.push_back(8'h0D); q1.push_back(8'h0A); lc1 = 0;
    end else if (lc2 == 3) begin
      q2.push_back(8'h0D); q2.push_back(8'h0A); lc2 = 0;
    end else begin
      lc2++;
    end
  endtask

  // Character monitors: scoreboard pop, hold-while-stalled check, parser.
  always @(negedge clk) begin
    if (b1.out_valid === 1'b1 && b1.out_ready === 1'b1) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL u1_char: got %h, expected no character", b1.out_char);
      end else begin
        exp1 = q1.pop_front();
        if (b1.out_char !== exp1) begin
          fails++;
          $display("FAIL u1_char: got %h, expected %h", b1.out_char, exp1);
        end
      end
      if (b1.out_char >= 8'h30 && b1.out_char <= 8'h39) begin
        pacc = {pacc[27:0], 4'(b1.out_char - 8'h30)}; pn++;
      end else if (b1.out_char >= 8'h41 && b1.out_char <= 8'h46) begin
        pacc = {pacc[27:0], 4'(b1.out_char - 8'h37)}; pn++;
      end else begin
        if (pn == 8) begin
          pw.push_back(pacc); pa.push_back(paddr); paddr += 32'd4;
        end
        pn = 0; pacc = '0;
      end
    end
    if (stall1 && !rs1) begin
      tests++;
      if (b1.out_valid !== 1'b1 || b1.out_char !== held1) begin
        fails++;
        $display("FAIL u1_hold: valid %b char %h, expected valid 1 char %h", b1.out_valid, b1.out_char, held1);
      end
    end
    stall1 = (b1.out_valid === 1'b1) && (b1.out_ready === 1'b0);
    held1  = b1.out_char;
    rs1    = rst1;
  end

  always @(negedge clk) begin
    if (b2.out_valid === 1'b1 && b2.out_ready === 1'b1) begin
      tests++;
      if (q2.size() == 0) begin
        fails++;
        $display("FAIL u2_char: got %h, expected no character", b2.out_char);
      end else begin
        exp2 = q2.pop_front();
        if (b2.out_char !== exp2) begin
          fails++;
          $display("FAIL u2_char: got %h, expected %h", b2.out_char, exp2);
        end
      end
    end
    if (stall2 && !rs2) begin
      tests++;
      if (b2.out_valid !== 1'b1 || b2.out_char !== held2) begin
        fails++;
        $display("FAIL u2_hold: valid %b char %h, expected valid 1 char %h", b2.out_valid, b2.out_char, held2);
      end
    end
    stall2 = (b2.out_valid === 1'b1) && (b2.out_ready === 1'b0);
    held2  = b2.out_char;
    rs2    = rst2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) b1.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input int which, input logic [31:0] w);
    logic done = 1'b0;
    if (which == 1) begin b1.in_valid = 1'b1; b1.in_data = w; end
    else            begin b2.in_valid = 1'b1; b2.in_data = w; end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((which == 1) ? (b1.in_ready === 1'b1) : (b2.in_ready === 1'b1)) begin
        push_word(which, w);
        done = 1'b1;
        tick();
        break;
      end
      tick();
    end
    if (which == 1) b1.in_valid = 1'b0; else b2.in_valid = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL send_timeout: unit %0d word %h not accepted, expected acceptance", which, w);
    end
  endtask

  task automatic wait_idle(input int which);
    logic done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (which == 1 ? (b1.busy === 1'b0 && q1.size() == 0) : (b2.busy === 1'b0 && q2.size() == 0)) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    tick();
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL idle_timeout: unit %0d still busy, %0d chars pending, expected idle", which,
               which == 1 ? q1.size() : q2.size());
    end
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst2 = 1'b1;
    b1.in_valid = 0; b1.in_data = '0; b1.flush = 0; b1.out_ready = 1;
    b2.in_valid = 0; b2.in_data = '0; b2.flush = 0; b2.out_ready = 1;
    tick(); tick();
    @(negedge clk);
    tests += 4;
    if (b1.out_valid !== 1'b0 || b2.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: %b %b, expected 0 0", b1.out_valid, b2.out_valid);
    end
    if (b1.sent_address !== 32'd0 || b2.sent_address !== 4'd0) begin
      fails++; $display("FAIL reset_addr: %h %h, expected 0 0", b1.sent_address, b2.sent_address);
    end
    if (b1.busy !== 1'b0 || b2.busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy: %b %b, expected 0 0", b1.busy, b2.busy);
    end
    if (b1.in_ready !== 1'b0 || b2.in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_in_ready_held: %b %b, expected 0 0", b1.in_ready, b2.in_ready);
    end
    tick();
    rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    tests++;
    if (b1.in_ready !== 1'b1 || b2.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready_rel: %b %b, expected 1 1", b1.in_ready, b2.in_ready);
    end
    tick();
  endtask

  task automatic test_single_line();
    b1.out_ready = 1'b1;
    send(1, 32'h1234ABCD);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (b1.out_valid !== 1'b1) begin
        fails++; $display("FAIL single_rate: cycle %0d out_valid %b, expected 1", i, b1.out_valid);
      end
      tick();
    end
    @(negedge clk);
    tests += 2;
    if (b1.busy !== 1'b0 || b1.in_ready !== 1'b1) begin
      fails++; $display("FAIL single_idle: busy %b in_ready %b, expected 0 1", b1.busy, b1.in_ready);
    end
    if (b1.sent_address !== 32'd4) begin
      fails++; $display("FAIL single_addr: %h, expected 4", b1.sent_address);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001;
    logic got = 1'b0;
    send(1, 32'h1234ABCD);
    b1.in_valid = 1'b1; b1.in_data = 32'hCAFE0123;
    for (int k = 0; k < 200; k++) begin
      b1.out_ready = pat[k % 4];
      @(negedge clk);
      tests++;
      if (b1.busy === 1'b1) begin
        if (b1.in_ready !== 1'b0) begin
          fails++; $display("FAIL bp_in_ready: %b while busy, expected 0", b1.in_ready);
        end
      end else if (b1.in_ready !== 1'b1) begin
        fails++; $display("FAIL bp_in_ready_idle: %b, expected 1", b1.in_ready);
      end else begin
        push_word(1, 32'hCAFE0123);
        got = 1'b1;
      end
      tick();
      if (got) break;
    end
    b1.in_valid = 1'b0; b1.out_ready = 1'b1;
    tests++;
    if (!got) begin
      fails++; $display("FAIL bp_second_word: not accepted, expected acceptance after LF");
    end
    wait_idle(1);
  endtask

  task automatic test_reset_mid_word();
    b1.out_ready = 1'b1;
    send(1, 32'hDEADBEEF);
    tick(); tick(); tick();
    rst1 = 1'b1; b1.out_ready = 1'b0;
    q1.delete(); lc1 = 0;
    @(negedge clk);
    tests++;
    if (b1.in_ready !== 1'b0) begin
      fails++; $display("FAIL rst_mid_in_ready: %b during reset, expected 0", b1.in_ready);
    end
    tick();
    @(negedge clk);
    tests += 2;
    if (b1.out_valid !== 1'b0 || b1.busy !== 1'b0) begin
      fails++; $display("FAIL rst_mid_valid: valid %b busy %b, expected 0 0", b1.out_valid, b1.busy);
    end
    if (b1.sent_address !== 32'd0) begin
      fails++; $display("FAIL rst_mid_addr: %h, expected 0", b1.sent_address);
    end
    tick();
    rst1 = 1'b0;
    @(negedge clk);
    tests++;
    if (b1.in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid_in_ready_rel: %b, expected 1", b1.in_ready);
    end
    tick();
    b1.out_ready = 1'b1;
    send(1, 32'h89ABCDEF);
    wait_idle(1);
  endtask

  task automatic test_flush();
    b2.out_ready = 1'b1;
    send(2, 32'h00000000);
    send(2, 32'hFFFFFFFF);
    wait_idle(2);
    // Partial line: flush emits CR LF
    b2.flush = 1'b1;
    @(negedge clk);
    tests++;
    if (b2.in_ready !== 1'b0) begin
      fails++; $display("FAIL flush_in_ready: %b, expected 0", b2.in_ready);
    end
    q2.push_back(8'h0D); q2.push_back(8'h0A); lc2 = 0;
    tick();
    b2.flush = 1'b0;
    wait_idle(2);
    // Empty line: flush ignored
    b2.flush = 1'b1;
    @(negedge clk);
    tests++;
    if (b2.in_ready !== 1'b1) begin
      fails++; $display("FAIL flush_empty_in_ready: %b, expected 1", b2.in_ready);
    end
    tick();
    b2.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (b2.out_valid !== 1'b0 || b2.busy !== 1'b0) begin
        fails++; $display("FAIL flush_empty_quiet: valid %b busy %b, expected 0 0", b2.out_valid, b2.busy);
      end
      tick();
    end
    send(2, 32'h0F1E2D3C);
    wait_idle(2);
    tests++;
    if (b2.sent_address !== 4'd12) begin
      fails++; $display("FAIL flush_addr: %h, expected c", b2.sent_address);
    end
    // Flush beats a simultaneous word
    b2.in_valid = 1'b1; b2.in_data = 32'h55555555; b2.flush = 1'b1;
    @(negedge clk);
    tests++;
    if (b2.in_ready !== 1'b0) begin
      fails++; $display("FAIL flush_vs_word: in_ready %b, expected 0", b2.in_ready);
    end
    q2.push_back(8'h0D); q2.push_back(8'h0A); lc2 = 0;
    tick();
    b2.in_valid = 1'b0; b2.flush = 1'b0;
    wait_idle(2);
    tests++;
    if (b2.sent_address !== 4'd12) begin
      fails++; $display("FAIL flush_vs_word_addr: %h, expected c", b2.sent_address);
    end
  endtask

  task automatic test_addr_wrap();
    send(2, 32'hA5A5A5A5);
    wait_idle(2);
    tests++;
    if (b2.sent_address !== 4'd0) begin
      fails++; $display("FAIL addr_wrap: %h, expected 0", b2.sent_address);
    end
  endtask

  task automatic test_loopback();
    logic [31:0] sent[$];
    logic [31:0] w;
    rst1 = 1'b1; tick(); tick(); rst1 = 1'b0;
    q1.delete(); lc1 = 0;
    pw.delete(); pa.delete(); pn = 0; pacc = '0; paddr = '0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      sent.push_back(w);
      send(1, w);
    end
    wait_idle(1);
    rand_rdy = 1'b0;
    b1.out_ready = 1'b1;
    tests++;
    if (pw.size() != 256) begin
      fails++; $display("FAIL loop_count: %0d words parsed, expected 256", pw.size());
    end
    for (int i = 0; i < 256 && i < pw.size(); i++) begin
      tests++;
      if (pw[i] !== sent[i] || pa[i] !== 32'(i * 4)) begin
        fails++; $display("FAIL loop_word: %0d got %h@%h, expected %h@%h", i, pw[i], pa[i], sent[i], 32'(i * 4));
      end
    end
    tests++;
    if (b1.sent_address !== 32'h400) begin
      fails++; $display("FAIL loop_addr: %h, expected 400", b1.sent_address);
    end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_backpressure();
    test_reset_mid_word();
    test_flush();
    test_addr_wrap();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
